revaluate_batch_sequencer: RTL

- Top-level controller that runs the revaluate datapath over a contiguous range of file indices.
- For each index it issues a read pulse, then a revaluate start, waits for done, then issues a write pulse.
- Replaces the single-file start/finish sequencing with batch operation: one start processes first_index..last_index, followed by a single finish pulse.
- Sits between the testbench/host and the revaluate datapath, and drives its file_index, read_file, write_file and revaluate_start inputs.

---
 rtl/revaluate_batch_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/revaluate_batch_sequencer.sv
// Batch sequencer: walks first_index..last_index issuing read / revaluate / write per file.
// Define REVALUATE_TIMEOUT_EN to add a WAIT watchdog and the timeout_err output.
module revaluate_batch_sequencer #(
    parameter int INDEX_W        = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INDEX_W-1:0] first_index,
    input  logic [INDEX_W-1:0] last_index,
    output logic [INDEX_W-1:0] file_index,
    output logic               read_file,
    output logic               revaluate_start,
    input  logic               revaluate_done,
    output logic               write_file,
    output logic               busy,
    output logic               finish,
    output logic               range_err,
    output logic [INDEX_W:0]   files_done
`ifdef REVALUATE_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    generate
        if (INDEX_W < 1) begin : g_bad_index_w
            $error("INDEX_W must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [INDEX_W-1:0] r_file_index;
    logic [INDEX_W-1:0] r_last_index;
    logic               r_range_err;
    logic [INDEX_W:0]   r_files_done;

    logic               w_accept;
    logic               w_range_bad;
    logic               w_last_file;
    logic               w_timeout_hit;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_range_bad = (first_index > last_index);
    // Termination by equality before the increment means last=all-ones never wraps.
    assign w_last_file = (r_file_index == r_last_index);

`ifdef REVALUATE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout_err;

    // Counter is zeroed in RUN so the first WAIT cycle sees 0.
    assign w_timeout_hit = (r_state == S_WAIT) && !revaluate_done && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            end

            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_range_bad ? S_DONE : S_READ;
                end
            end
            S_READ:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_WAIT;
            S_WAIT: begin
                if (revaluate_done) begin
                    w_state_next = S_WRITE;
                end else if (w_timeout_hit) begin
                    w_state_next = S_DONE;
                end
            end
            S_WRITE: w_state_next = w_last_file ? S_DONE : S_READ;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_file_index <= '0;
            r_last_index <= '0;
            r_range_err  <= 1'b0;
            r_files_done <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_index <= last_index;
                r_range_err  <= w_range_bad;
                r_files_done <= '0;
                if (!w_range_bad) begin
                    r_file_index <= first_index;
                end
            end else if (r_state == S_WRITE) begin
                r_files_done <= r_files_done + (INDEX_W + 1)'(1);
                if (!w_last_file) begin
                    r_file_index <= r_file_index + INDEX_W'(1);
                end
            end
        end
    end

    // Strobes are pure state decodes so each is exactly one cycle per visit.
    assign read_file       = (r_state == S_READ);
    assign revaluate_start = (r_state == S_RUN);
    assign write_file      = (r_state == S_WRITE);
    assign finish          = (r_state == S_DONE);
    assign busy            = (r_state != S_IDLE);
    assign file_index      = r_file_index;
    assign range_err       = r_range_err;
    assign files_done      = r_files_done;

endmodule
